// File: rtl/hex_reader_pkg.sv
// Shared types for the seven-segment reader: segment patterns, symbols, status and FSM states.
package hex_reader_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digits occupy codes 0-9 so the enum value doubles as the digit value.
  typedef enum logic [3:0] {
    SYM_D0, SYM_D1, SYM_D2, SYM_D3, SYM_D4, SYM_D5, SYM_D6, SYM_D7, SYM_D8, SYM_D9,
    SYM_B, SYM_A, SYM_D, SYM_N, SYM_BLANK, SYM_UNK
  } sym_e;

  typedef enum logic [1:0] {ST_OK, ST_BAD, ST_BANANA, ST_ERR} status_e;

  typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} state_e;

  function automatic logic is_digit(input sym_e s);
    return (s <= SYM_D9);
  endfunction

endpackage

// File: rtl/hex_reader_if.sv
// Bus between the display source / result consumer and hex_reader.
interface hex_reader_if;
  import hex_reader_pkg::*;

  logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic       start;
  logic       ready;
  logic       busy;
  logic       valid;
  status_e    status;
  logic [3:0] dig_a;
  logic [3:0] dig_b;
  logic       a_ok;
  logic       b_ok;

  modport master (
    output HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, start, ready,
    input  busy, valid, status, dig_a, dig_b, a_ok, b_ok
  );

  modport slave (
    input  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, start, ready,
    output busy, valid, status, dig_a, dig_b, a_ok, b_ok
  );
endinterface

// File: rtl/hex_reader_seg_classify.sv
// Combinational map from an active-low {g..a} segment pattern to a symbol.
module seg_classify
  import hex_reader_pkg::*;
(
  input  logic [6:0] pat,
  output sym_e       sym
);
  always_comb begin
    case (pat)
      SEG_0:     sym = SYM_D0;
      SEG_1:     sym = SYM_D1;
      SEG_2:     sym = SYM_D2;
      SEG_3:     sym = SYM_D3;
      SEG_4:     sym = SYM_D4;
      SEG_5:     sym = SYM_D5;
      SEG_6:     sym = SYM_D6;
      SEG_7:     sym = SYM_D7;
      SEG_8:     sym = SYM_D8;
      SEG_9:     sym = SYM_D9;
      SEG_B:     sym = SYM_B;
      SEG_A:     sym = SYM_A;
      SEG_D:     sym = SYM_D;
      SEG_N:     sym = SYM_N;
      SEG_BLANK: sym = SYM_BLANK;
      default:   sym = SYM_UNK;
    endcase
  end
endmodule

// File: rtl/hex_reader.sv
// Snapshots six seven-segment patterns, classifies them one per cycle and reports a status.
// Build option HEXRD_STRICT_EN: any unknown symbol forces ERR (otherwise UNK in HEX2 reads as blank).
module hex_reader
  import hex_reader_pkg::*;
(
  input logic         CLOCK_50,
  input logic         RESET_N,
  hex_reader_if.slave bus
);

  state_e          state_q, state_d;
  logic [5:0][6:0] snap_q, snap_d;
  logic [2:0]      idx_q, idx_d;
  sym_e            sym_q [6];
  sym_e            sym_d [6];
  logic            valid_q, valid_d;
  status_e         status_q, status_d;
  logic [3:0]      dig_a_q, dig_a_d, dig_b_q, dig_b_d;
  logic            a_ok_q, a_ok_d, b_ok_q, b_ok_d;

  logic [5:0][6:0] hex_in;
  logic [6:0]      sel_pat;
  sym_e            cls_sym;

  status_e         ev_status;
  logic [3:0]      ev_dig_a, ev_dig_b;
  logic            ev_a_ok, ev_b_ok;

  assign hex_in = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};

  always_comb begin
    sel_pat = SEG_BLANK;
    for (int i = 0; i < 6; i++)
      if (idx_q == 3'(i)) sel_pat = snap_q[i];
  end

  seg_classify u_cls (.pat(sel_pat), .sym(cls_sym));

  // Result evaluation over the six stored symbols.
  always_comb begin
    sym_e h2;
    logic strict_kill;
    logic a_dig, b_dig;
    h2 = sym_q[2];
`ifdef HEXRD_STRICT_EN
    strict_kill = 1'b0;
    for (int i = 0; i < 6; i++)
      if (sym_q[i] == SYM_UNK) strict_kill = 1'b1;
`else
    strict_kill = 1'b0;
    if (h2 == SYM_UNK) h2 = SYM_BLANK;
`endif
    a_dig     = is_digit(sym_q[1]);
    b_dig     = is_digit(sym_q[0]);
    ev_status = ST_ERR;
    ev_dig_a  = '0;
    ev_dig_b  = '0;
    ev_a_ok   = 1'b0;
    ev_b_ok   = 1'b0;
    if (!strict_kill) begin
      if (sym_q[5] == SYM_B && sym_q[4] == SYM_A && sym_q[3] == SYM_N &&
          sym_q[2] == SYM_A && sym_q[1] == SYM_N && sym_q[0] == SYM_A) begin
        ev_status = ST_BANANA;
      end else if ((sym_q[5] == SYM_BLANK && sym_q[4] == SYM_BLANK && sym_q[3] == SYM_BLANK &&
                    h2 == SYM_BLANK && a_dig && b_dig) ||
                   (sym_q[5] == SYM_B && sym_q[4] == SYM_A && sym_q[3] == SYM_D &&
                    h2 == SYM_BLANK)) begin
        ev_status = (sym_q[5] == SYM_B) ? ST_BAD : ST_OK;
        ev_a_ok   = a_dig;
        ev_b_ok   = b_dig;
        ev_dig_a  = a_dig ? 4'(sym_q[1]) : 4'd0;
        ev_dig_b  = b_dig ? 4'(sym_q[0]) : 4'd0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    sym_d    = sym_q;
    valid_d  = valid_q;
    status_d = status_q;
    dig_a_d  = dig_a_q;
    dig_b_d  = dig_b_q;
    a_ok_d   = a_ok_q;
    b_ok_d   = b_ok_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d  = hex_in;
          idx_d   = 3'd5;
          state_d = SCAN;
        end
      end
      SCAN: begin
        for (int i = 0; i < 6; i++)
          if (idx_q == 3'(i)) sym_d[i] = cls_sym;
        if (idx_q == 3'd0) state_d = EVAL;
        else               idx_d   = idx_q - 3'd1;
      end
      EVAL: begin
        status_d = ev_status;
        dig_a_d  = ev_dig_a;
        dig_b_d  = ev_dig_b;
        a_ok_d   = ev_a_ok;
        b_ok_d   = ev_b_ok;
        state_d  = DONE;
      end
      DONE: begin
        // valid rises one cycle into DONE; ready is only honoured once it is up.
        valid_d = 1'b1;
        if (valid_q && bus.ready) begin
          valid_d = 1'b0;
          if (bus.start) begin
            snap_d  = hex_in;
            idx_d   = 3'd5;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      idx_q    <= '0;
      for (int i = 0; i < 6; i++) sym_q[i] <= SYM_D0;
      valid_q  <= 1'b0;
      status_q <= ST_OK;
      dig_a_q  <= '0;
      dig_b_q  <= '0;
      a_ok_q   <= 1'b0;
      b_ok_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      sym_q    <= sym_d;
      valid_q  <= valid_d;
      status_q <= status_d;
      dig_a_q  <= dig_a_d;
      dig_b_q  <= dig_b_d;
      a_ok_q   <= a_ok_d;
      b_ok_q   <= b_ok_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.valid  = valid_q;
  assign bus.status = status_q;
  assign bus.dig_a  = dig_a_q;
  assign bus.dig_b  = dig_b_q;
  assign bus.a_ok   = a_ok_q;
  assign bus.b_ok   = b_ok_q;

endmodule

// File: tb/tb_hex_reader.sv
// Scoreboard bench for hex_reader: directed vectors push expected results, a monitor checks them.
module tb_hex_reader;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] UK = 7'b1010101;

  typedef struct {
    int st;
    int da;
    int db;
    int ao;
    int bo;
    int vcyc;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  exp_t sbq[$];
  logic vprev    = 1'b0;

  hex_reader_if bus();

  hex_reader dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int st, input int da, input int db, input int ao, input int bo);
    exp_t e;
    e.st = st; e.da = da; e.db = db; e.ao = ao; e.bo = bo; e.vcyc = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_hex(input logic [41:0] v);
    {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0} = v;
  endtask

  // Called just after a rising edge; the next edge is the start-accept edge.
  task automatic launch(input logic [41:0] v, input exp_t e);
    set_hex(v);
    bus.start = 1'b1;
    e.vcyc = cyc + 9;
    sbq.push_back(e);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic accept();
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},   int'(bus.busy),   0);
    chk({nm, "_valid"},  int'(bus.valid),  0);
    chk({nm, "_status"}, int'(bus.status), 0);
    chk({nm, "_dig_a"},  int'(bus.dig_a),  0);
    chk({nm, "_dig_b"},  int'(bus.dig_b),  0);
    chk({nm, "_a_ok"},   int'(bus.a_ok),   0);
    chk({nm, "_b_ok"},   int'(bus.b_ok),   0);
  endtask

  task automatic run_vec(input string nm, input logic [41:0] v, input exp_t e);
    launch(v, e);
    wait_valid(nm);
    accept();
  endtask

  // Monitor: latency on the valid rising edge, result fields on each handshake.
  always @(negedge CLOCK_50) begin
    if (RESET_N) begin
      if (bus.valid && !vprev) begin
        if (sbq.size() > 0) chk("valid_latency", cyc, sbq[0].vcyc);
        else                chk("spurious_valid", 1, 0);
      end
      if (bus.valid && bus.ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("status", int'(bus.status), e.st);
          chk("dig_a",  int'(bus.dig_a),  e.da);
          chk("dig_b",  int'(bus.dig_b),  e.db);
          chk("a_ok",   int'(bus.a_ok),   e.ao);
          chk("b_ok",   int'(bus.b_ok),   e.bo);
        end
      end
    end
    vprev = bus.valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bus.start = 1'b0;
    bus.ready = 1'b0;
    set_hex({BL, BL, BL, BL, BL, BL});
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_zero("reset");

    // First start on the first edge after reset release.
    RESET_N = 1'b1;
    run_vec("ok73", {BL, BL, BL, BL, 7'b1111000, 7'b0110000}, mk(0, 7, 3, 1, 1));

    step();
    run_vec("bad_b3", {7'b0000011, 7'b0001000, 7'b0100001, BL, BL, 7'b0110000}, mk(1, 0, 3, 0, 1));

    step();
    run_vec("banana", {7'b0000011, 7'b0001000, 7'b0101011, 7'b0001000, 7'b0101011, 7'b0001000},
            mk(2, 0, 0, 0, 0));

    step();
    run_vec("unk_hex1", {BL, BL, BL, BL, UK, BL}, mk(3, 0, 0, 0, 0));

    step();
    run_vec("ok01", {BL, BL, BL, BL, 7'b1000000, 7'b1111001}, mk(0, 0, 1, 1, 1));

`ifdef HEXRD_STRICT_EN
    e = mk(3, 0, 0, 0, 0);
`else
    e = mk(1, 8, 9, 1, 1);
`endif
    step();
    run_vec("bad_unk_hex2", {7'b0000011, 7'b0001000, 7'b0100001, UK, 7'b0000000, 7'b0010000}, e);

    step();
    run_vec("ok_hex1_letter", {BL, BL, BL, BL, 7'b0000011, 7'b0100100}, mk(3, 0, 0, 0, 0));

    // start and HEX changes while scanning must not disturb the in-flight result.
    step();
    launch({BL, BL, BL, BL, 7'b0011001, 7'b0000010}, mk(0, 4, 6, 1, 1));
    step();
    step();
    set_hex({7'b0000011, 7'b0001000, 7'b0101011, 7'b0001000, 7'b0101011, 7'b0001000});
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid("scan_ignore");
    accept();
    step();
    step();
    chk("idle_after_ignore_busy", int'(bus.busy), 0);

    // Hold in DONE without ready, then back-to-back accept+start.
    step();
    launch({7'b0000011, 7'b0001000, 7'b0100001, BL, 7'b0010010, BL}, mk(1, 5, 0, 1, 0));
    wait_valid("hold");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",  int'(bus.valid),  1);
      chk("hold_status", int'(bus.status), 1);
      chk("hold_dig_a",  int'(bus.dig_a),  5);
      chk("hold_a_ok",   int'(bus.a_ok),   1);
      chk("hold_b_ok",   int'(bus.b_ok),   0);
      set_hex(42'({$urandom(), $urandom()}));
      bus.start = (i < 2);
      step();
    end
    bus.ready = 1'b1;
    launch({BL, BL, BL, BL, 7'b0100100, 7'b0010010}, mk(0, 2, 5, 1, 1));
    bus.ready = 1'b0;
    chk("b2b_busy", int'(bus.busy), 1);
    set_hex({BL, BL, BL, BL, BL, BL});
    wait_valid("b2b");
    accept();

    // Asynchronous reset in the middle of a scan (index 3).
    step();
    set_hex({BL, BL, BL, BL, 7'b1111000, 7'b0110000});
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    RESET_N = 1'b0;
    #1;
    chk_zero("midscan_reset");
    step();
    RESET_N = 1'b1;
    run_vec("after_reset", {BL, BL, BL, BL, 7'b0010000, 7'b0000000}, mk(0, 9, 8, 1, 1));

    repeat (12) step();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
